ball_renderer: RTL and testbench
================================

// Module: ball_renderer
// PURPOSE
//   Pixel-generation stage directly downstream of the VGA timing generator. Consumes col/row/visible
//   and raw hsync/vsync, draws a square ball that bounces off the screen edges over a solid
//   background, and emits 6-bit RGB plus syncs delayed to match the 2-cycle pixel pipeline.
//   Ball position updates once per frame during vertical blanking, so no tearing.
// PARAMETERS
//   H_VISIBLE   640     visible columns; right bound for the ball
//   V_VISIBLE   480     visible rows; bottom bound for the ball
//   BALL_SIZE   16      ball edge length, pixels
//   SPEED       4       pixels moved per frame on each axis
//   X0          100     reset X of ball top-left corner
//   Y0          100     reset Y of ball top-left corner
//   BALL_COLOR  6'b110000  RGB222 ball colour
//   BG_COLOR    6'b000011  RGB222 background colour
// PORTS
//   clk          in   1   pixel clock, same clock as the timing generator
//   rst          in   1   asynchronous, active-high reset
//   col          in   10  current column from timing generator
//   row          in   10  current row from timing generator
//   visible      in   1   1 = active video pixel
//   hsync_in     in   1   active-low hsync from timing generator
//   vsync_in     in   1   active-low vsync from timing generator
//   enable       in   1   1 = ball moves each frame; 0 = position frozen
//   rgb          out  6   {R[1:0],G[1:0],B[1:0]}, pipeline-aligned
//   hsync_out    out  1   hsync_in delayed 2 cycles
//   vsync_out    out  1   vsync_in delayed 2 cycles
//   frame_tick   out  1   1-cycle pulse when a frame update starts
//   bounce       out  1   1-cycle pulse when any wall reflection occurs in an update
// BEHAVIOUR
//   Reset (async): x=X0, y=Y0, dir_x=dir_y=1 (right/down), state=WAIT_FRAME, rgb=0,
//     hsync_out=vsync_out=1, frame_tick=0, bounce=0, pipeline valid/sync regs cleared to blank/1.
//   Pipeline, latency exactly 2: S1 registers visible, syncs and inside =
//     (col>=x)&&(col<x+BALL_SIZE)&&(row>=y)&&(row<y+BALL_SIZE), computed with 11-bit sums.
//     S2: rgb = !visible_d ? 0 : inside_d ? BALL_COLOR : BG_COLOR; syncs pass through unchanged.
//   FSM: WAIT_FRAME -> UPDATE_X when row==V_VISIBLE && col==0 (once per frame, blanking);
//     frame_tick=1 that cycle regardless of enable. If enable=0, stay in WAIT_FRAME.
//     UPDATE_X (1 cycle) -> UPDATE_Y (1 cycle) -> WAIT_FRAME.
//   Axis update (11-bit arithmetic, MAX_X=H_VISIBLE-BALL_SIZE, MAX_Y=V_VISIBLE-BALL_SIZE):
//     dir=1: if pos+SPEED >= MAX then pos=MAX, dir=0, hit else pos+=SPEED.
//     dir=0: if pos <= SPEED then pos=0, dir=1, hit else pos-=SPEED.
//   bounce pulses 1 cycle in the cycle after UPDATE_Y if X or Y hit; both hit = single pulse.
//   Position registers change only in UPDATE_X/UPDATE_Y; inside uses stable x/y during visible area.
//   Reset mid-frame or mid-update: all state returns to reset values immediately; the next
//     frame start after release triggers a normal update.
//   Inputs col/row assumed from same clock; no CDC inside this block.
// TESTING
//   Pipeline: col=20,row=20,visible=1 at cycle t -> rgb=BG_COLOR at t+2; visible=0 -> rgb=0.
//   Ball draw after reset: col=100..115,row=100 -> BALL_COLOR; col=116 -> BG_COLOR; col=99 -> BG.
//   Sync align: hsync_in low pulse cycles 656..751 -> hsync_out low cycles 658..753.
//   Motion: enable=1, one frame -> frame_tick once, x=104,y=104; enable=0 -> x,y unchanged.
//   Right wall: force x=620,dir_x=1 -> x=624,dir_x=0,bounce=1; next frame x=620,no bounce.
//   Corner + reset: x=624,y=464 moving right/down -> single bounce pulse, dirs both flip;
//     assert rst mid-UPDATE_X -> x=100,y=100,rgb=0,syncs=1 immediately.

Source files
------------

// File: rtl/ball_renderer.sv
// Pixel stage after the VGA timing generator: draws a bouncing square ball over a solid
// background, with a 2-cycle pixel pipeline and once-per-frame position updates in blanking.
module ball_renderer #(
    parameter int          H_VISIBLE  = 640,
    parameter int          V_VISIBLE  = 480,
    parameter int          BALL_SIZE  = 16,
    parameter int          SPEED      = 4,
    parameter int          X0         = 100,
    parameter int          Y0         = 100,
    parameter logic [5:0]  BALL_COLOR = 6'b110000,
    parameter logic [5:0]  BG_COLOR   = 6'b000011
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] col,
    input  logic [9:0] row,
    input  logic       visible,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       enable,
    output logic [5:0] rgb,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       frame_tick,
    output logic       bounce
);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        UPDATE_X   = 2'd1,
        UPDATE_Y   = 2'd2
    } state_t;

    localparam logic [10:0] MAX_X   = 11'(H_VISIBLE - BALL_SIZE);
    localparam logic [10:0] MAX_Y   = 11'(V_VISIBLE - BALL_SIZE);
    localparam logic [10:0] SIZE_W  = 11'(BALL_SIZE);
    localparam logic [10:0] SPEED_W = 11'(SPEED);
    localparam logic [9:0]  ROW_START = 10'(V_VISIBLE);

    // One axis step: returns {hit, new_dir, new_pos}; walls clamp the position exactly.
    function automatic logic [11:0] axis_step(input logic [9:0] pos, input logic dir,
                                              input logic [10:0] max_pos);
        logic [10:0] sum_v;
        logic [11:0] res_v;
        sum_v = {1'b0, pos} + SPEED_W;
        if (dir) begin
            if (sum_v >= max_pos) res_v = {1'b1, 1'b0, max_pos[9:0]};
            else                  res_v = {1'b0, 1'b1, sum_v[9:0]};
        end else begin
            if ({1'b0, pos} <= SPEED_W) res_v = {1'b1, 1'b1, 10'd0};
            else                        res_v = {1'b0, 1'b0, pos - SPEED_W[9:0]};
        end
        return res_v;
    endfunction

    state_t      state_r, state_next_s;
    logic [9:0]  x_r, y_r;
    logic        dir_x_r, dir_y_r, hit_x_r, bounce_r;
    logic [11:0] step_x_s, step_y_s;
    logic        frame_start_s, upd_x_s, upd_y_s, tick_s, inside_s;
    logic        vis_d_r, inside_d_r, hs_d_r, vs_d_r;
    logic [5:0]  rgb_s, rgb_r;
    logic        hsync_r, vsync_r;

    assign frame_start_s = (row == ROW_START) && (col == 10'd0);
    assign step_x_s      = axis_step(x_r, dir_x_r, MAX_X);
    assign step_y_s      = axis_step(y_r, dir_y_r, MAX_Y);
    assign inside_s      = ({1'b0, col} >= {1'b0, x_r}) && ({1'b0, col} < ({1'b0, x_r} + SIZE_W)) &&
                           ({1'b0, row} >= {1'b0, y_r}) && ({1'b0, row} < ({1'b0, y_r} + SIZE_W));

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= WAIT_FRAME;
        else     state_r <= state_next_s;
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            WAIT_FRAME: begin
                if (frame_start_s && enable) state_next_s = UPDATE_X;
                else                         state_next_s = WAIT_FRAME;
            end
            UPDATE_X: state_next_s = UPDATE_Y;
            UPDATE_Y: state_next_s = WAIT_FRAME;
            default:  state_next_s = WAIT_FRAME;
        endcase
    end

    // FSM outputs; frame_tick fires on every frame start, even when motion is frozen
    always_comb begin
        tick_s  = 1'b0;
        upd_x_s = 1'b0;
        upd_y_s = 1'b0;
        case (state_r)
            WAIT_FRAME: tick_s  = frame_start_s;
            UPDATE_X:   upd_x_s = 1'b1;
            UPDATE_Y:   upd_y_s = 1'b1;
            default: begin
                tick_s  = 1'b0;
                upd_x_s = 1'b0;
                upd_y_s = 1'b0;
            end
        endcase
    end

    // Ball position/direction; X hit is held so one combined bounce pulse follows UPDATE_Y
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r      <= 10'(X0);
            y_r      <= 10'(Y0);
            dir_x_r  <= 1'b1;
            dir_y_r  <= 1'b1;
            hit_x_r  <= 1'b0;
            bounce_r <= 1'b0;
        end else begin
            if (upd_x_s) {hit_x_r, dir_x_r, x_r} <= step_x_s;
            if (upd_y_s) {dir_y_r, y_r} <= step_y_s[10:0];
            bounce_r <= upd_y_s && (hit_x_r || step_y_s[11]);
        end
    end

    // Pixel colour select for stage 2
    always_comb begin
        rgb_s = 6'd0;
        if (!vis_d_r)        rgb_s = 6'd0;
        else if (inside_d_r) rgb_s = BALL_COLOR;
        else                 rgb_s = BG_COLOR;
    end

    // Two-stage pixel pipeline keeping syncs aligned with colour
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vis_d_r    <= 1'b0;
            inside_d_r <= 1'b0;
            hs_d_r     <= 1'b1;
            vs_d_r     <= 1'b1;
            rgb_r      <= 6'd0;
            hsync_r    <= 1'b1;
            vsync_r    <= 1'b1;
        end else begin
            vis_d_r    <= visible;
            inside_d_r <= inside_s;
            hs_d_r     <= hsync_in;
            vs_d_r     <= vsync_in;
            rgb_r      <= rgb_s;
            hsync_r    <= hs_d_r;
            vsync_r    <= vs_d_r;
        end
    end

    assign rgb        = rgb_r;
    assign hsync_out  = hsync_r;
    assign vsync_out  = vsync_r;
    assign frame_tick = tick_s;
    assign bounce     = bounce_r;

endmodule

// File: tb/tb_ball_renderer.sv
// Directed self-checking bench for ball_renderer: pipeline, draw window, sync alignment,
// per-frame motion, wall and corner bounces, and asynchronous reset mid-update.
module tb_ball_renderer;

    localparam logic [5:0] BALL = 6'b110000;
    localparam logic [5:0] BG   = 6'b000011;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] col, row;
    logic       visible, hsync_in, vsync_in, enable;
    logic [5:0] rgb;
    logic       hsync_out, vsync_out, frame_tick, bounce;

    int errors = 0;
    int checks = 0;

    ball_renderer dut (
        .clk(clk), .rst(rst), .col(col), .row(row), .visible(visible),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .enable(enable),
        .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .frame_tick(frame_tick), .bounce(bounce)
    );

    always #5 clk = ~clk;

    // Present a visible pixel for one cycle and return the colour two cycles later.
    task automatic probe(input int c, input int r, output logic [5:0] px);
        @(negedge clk);
        col = 10'(c); row = 10'(r); visible = 1'b1;
        @(negedge clk);
        col = 10'd0; row = 10'd0; visible = 1'b0;
        @(negedge clk);
        px = rgb;
    endtask

    // One frame-start event; reports frame_tick and the number of bounce-high cycles.
    task automatic do_frame(output logic tick, output int bpulses);
        @(negedge clk);
        row = 10'd480; col = 10'd0;
        #1 tick = frame_tick;
        @(negedge clk);
        row = 10'd481; col = 10'd1;
        bpulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (bounce) bpulses++;
        end
        row = 10'd0; col = 10'd0;
    endtask

    task automatic run_frames(input int n, output int ticks, output int bounces);
        logic t;
        int   b;
        ticks = 0; bounces = 0;
        for (int i = 0; i < n; i++) begin
            do_frame(t, b);
            if (t) ticks++;
            bounces += b;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic expect_px(input string name, input int c, input int r, input logic [5:0] exp);
        logic [5:0] px;
        probe(c, r, px);
        checks++;
        if (px !== exp) begin
            errors++;
            $display("FAIL %s (%0d,%0d) got=%b exp=%b", name, c, r, px, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; col = 10'd0; row = 10'd0; visible = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1; enable = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rgb, hsync_out, vsync_out, frame_tick, bounce} !== {6'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got=%b %b %b %b %b exp=000000 1 1 0 0",
                     rgb, hsync_out, vsync_out, frame_tick, bounce);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_pipeline();
        @(negedge clk);
        col = 10'd20; row = 10'd20; visible = 1'b1;
        @(negedge clk);
        checks++;
        if (rgb !== 6'd0) begin errors++; $display("FAIL pipe_lat1 got=%b exp=%b", rgb, 6'd0); end
        @(negedge clk);
        checks++;
        if (rgb !== BG) begin errors++; $display("FAIL pipe_lat2 got=%b exp=%b", rgb, BG); end
        visible = 1'b0;
        @(negedge clk);
        checks++;
        if (rgb !== BG) begin errors++; $display("FAIL pipe_hold got=%b exp=%b", rgb, BG); end
        @(negedge clk);
        checks++;
        if (rgb !== 6'd0) begin errors++; $display("FAIL pipe_blank got=%b exp=%b", rgb, 6'd0); end
        col = 10'd0; row = 10'd0;
    endtask

    task automatic test_ball_draw();
        for (int c = 99; c <= 116; c++)
            expect_px("draw_row100", c, 100, (c >= 100 && c <= 115) ? BALL : BG);
        expect_px("draw_row99", 100, 99, BG);
        expect_px("draw_row115", 115, 115, BALL);
        expect_px("draw_row116", 115, 116, BG);
    endtask

    task automatic test_sync_align();
        logic exp_hs, exp_vs;
        logic [5:0] exp_rgb;
        repeat (2) @(negedge clk);
        row = 10'd10;
        for (int c = 0; c < 800; c++) begin
            exp_hs  = !(c >= 658 && c <= 753);
            exp_vs  = !(c >= 402 && c <= 404);
            exp_rgb = (c >= 2 && c < 642) ? BG : 6'd0;
            checks++;
            if (hsync_out !== exp_hs || vsync_out !== exp_vs || rgb !== exp_rgb) begin
                errors++;
                $display("FAIL sync_align c=%0d got=%b%b %b exp=%b%b %b",
                         c, hsync_out, vsync_out, rgb, exp_hs, exp_vs, exp_rgb);
            end
            col      = 10'(c);
            visible  = (c < 640);
            hsync_in = !(c >= 656 && c <= 751);
            vsync_in = !(c >= 400 && c <= 402);
            @(negedge clk);
        end
        col = 10'd0; row = 10'd0; visible = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    endtask

    task automatic test_motion();
        logic t;
        int   b;
        enable = 1'b1;
        do_frame(t, b);
        checks++;
        if (t !== 1'b1 || b != 0) begin errors++; $display("FAIL motion_tick got=%b,%0d exp=1,0", t, b); end
        expect_px("motion_tl", 104, 104, BALL);
        expect_px("motion_left", 103, 104, BG);
        expect_px("motion_top", 104, 103, BG);
        expect_px("motion_br", 119, 119, BALL);
        expect_px("motion_right", 120, 119, BG);
        enable = 1'b0;
        do_frame(t, b);
        checks++;
        if (t !== 1'b1 || b != 0) begin errors++; $display("FAIL frozen_tick got=%b,%0d exp=1,0", t, b); end
        expect_px("frozen_tl", 104, 104, BALL);
        expect_px("frozen_left", 103, 104, BG);
    endtask

    task automatic test_right_wall();
        logic t;
        int   ticks, b;
        pulse_reset();
        enable = 1'b1;
        run_frames(130, ticks, b);
        checks++;
        if (ticks != 130 || b != 1) begin errors++; $display("FAIL wall_run got=%0d,%0d exp=130,1", ticks, b); end
        expect_px("wall_pre", 620, 308, BALL);
        expect_px("wall_pre_l", 619, 308, BG);
        do_frame(t, b);
        checks++;
        if (b != 1) begin errors++; $display("FAIL wall_bounce got=%0d exp=1", b); end
        expect_px("wall_hit", 624, 304, BALL);
        expect_px("wall_hit_l", 623, 304, BG);
        expect_px("wall_hit_r", 639, 304, BALL);
        do_frame(t, b);
        checks++;
        if (b != 0) begin errors++; $display("FAIL wall_after got=%0d exp=0", b); end
        expect_px("wall_back", 620, 300, BALL);
        expect_px("wall_back_r", 636, 300, BG);
    endtask

    task automatic test_corner_and_reset();
        logic t;
        int   ticks, b;
        pulse_reset();
        enable = 1'b1;
        run_frames(4498, ticks, b);
        checks++;
        if (ticks != 4498 || b != 66) begin errors++; $display("FAIL corner_run got=%0d,%0d exp=4498,66", ticks, b); end
        do_frame(t, b);
        checks++;
        if (b != 1) begin errors++; $display("FAIL corner_bounce got=%0d exp=1", b); end
        expect_px("corner_tl", 624, 464, BALL);
        expect_px("corner_br", 639, 479, BALL);
        expect_px("corner_left", 623, 464, BG);
        expect_px("corner_top", 624, 463, BG);
        do_frame(t, b);
        checks++;
        if (b != 0) begin errors++; $display("FAIL corner_after got=%0d exp=0", b); end
        expect_px("corner_back", 620, 460, BALL);
        expect_px("corner_back_r", 636, 460, BG);
        expect_px("corner_back_b", 620, 476, BG);

        // Fill the pipeline with visible background and low syncs, then reset during UPDATE_X
        @(negedge clk);
        col = 10'd200; row = 10'd200; visible = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        repeat (3) @(negedge clk);
        row = 10'd480; col = 10'd0;
        @(posedge clk);
        #1;
        checks++;
        if (rgb !== BG || hsync_out !== 1'b0 || vsync_out !== 1'b0) begin
            errors++;
            $display("FAIL prereset got=%b %b%b exp=%b 00", rgb, hsync_out, vsync_out, BG);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rgb !== 6'd0 || hsync_out !== 1'b1 || vsync_out !== 1'b1 || bounce !== 1'b0) begin
            errors++;
            $display("FAIL midupdate_reset got=%b %b%b %b exp=000000 11 0", rgb, hsync_out, vsync_out, bounce);
        end
        @(negedge clk);
        col = 10'd0; row = 10'd0; visible = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_px("rst_home", 100, 100, BALL);
        expect_px("rst_home_l", 99, 100, BG);
        do_frame(t, b);
        checks++;
        if (t !== 1'b1 || b != 0) begin errors++; $display("FAIL rst_frame got=%b,%0d exp=1,0", t, b); end
        expect_px("rst_moved", 104, 104, BALL);
        expect_px("rst_moved_l", 103, 104, BG);
    endtask

    initial begin
        test_reset();
        test_pipeline();
        test_ball_draw();
        test_sync_align();
        test_motion();
        test_right_wall();
        test_corner_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
